// File: rtl/sr_latch_if.sv
// Handshake bundle for sr_latch: enable, set/reset requests and state outputs.
// With SR_ILLEGAL_CNT_EN defined the bundle also carries the 8-bit illegal_cnt.
interface sr_latch_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic             invalid;
`ifdef SR_ILLEGAL_CNT_EN
    logic [7:0]       illegal_cnt;

    modport master (output en, S, R, input Q, Qn, invalid, illegal_cnt);
    modport slave  (input en, S, R, output Q, Qn, invalid, illegal_cnt);
`else
    modport master (output en, S, R, input Q, Qn, invalid);
    modport slave  (input en, S, R, output Q, Qn, invalid);
`endif
endinterface

// File: rtl/sr_latch.sv
// Clock-enabled vector of SR flags with complementary outputs and a conflict pulse.
// Optional SR_ILLEGAL_CNT_EN adds a saturating 8-bit count of conflict edges.
module sr_bit #(
    parameter logic RESET_BIT   = 1'b0,
    parameter int   BOTH_POLICY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q
);
    logic q_nxt;

    always_comb begin
        q_nxt = q;
        if (en) begin
            unique case ({s, r})
                2'b01:   q_nxt = 1'b0;
                2'b10:   q_nxt = 1'b1;
                2'b11: begin
                    case (BOTH_POLICY)
                        1:       q_nxt = 1'b1;
                        2:       q_nxt = 1'b0;
                        3:       q_nxt = ~q;
                        default: q_nxt = q;
                    endcase
                end
                default: q_nxt = q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RESET_BIT;
        else     q <= q_nxt;
    end
endmodule

module sr_latch #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               BOTH_POLICY = 0
) (
    input  logic        clk,
    input  logic        rst,
    sr_latch_if.slave   bus
);
    logic [WIDTH-1:0] q;
    logic             conflict;
    logic             invalid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_bit #(
            .RESET_BIT  (RESET_VAL[i]),
            .BOTH_POLICY(BOTH_POLICY)
        ) u_bit (
            .clk(clk),
            .rst(rst),
            .en (bus.en),
            .s  (bus.S[i]),
            .r  (bus.R[i]),
            .q  (q[i])
        );
    end

    // Qn comes off the same flops so Q and Qn can never disagree, even in reset.
    assign bus.Q  = q;
    assign bus.Qn = ~q;

    assign conflict = bus.en & (|(bus.S & bus.R));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) invalid_q <= 1'b0;
        else     invalid_q <= conflict;
    end

    assign bus.invalid = invalid_q;

`ifdef SR_ILLEGAL_CNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         cnt <= 8'd0;
        else if (conflict && cnt != 8'hFF) cnt <= cnt + 8'd1;
    end

    assign bus.illegal_cnt = cnt;
`endif
endmodule

// File: tb/tb_sr_latch.sv
// Bench for sr_latch: directed plan steps followed by random traffic, all
// outputs of several parameterisations compared against a set-algebra model.
module tb_sr_latch;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       s1, r1;
    logic [3:0] s4, r4;

    localparam logic [3:0] RV4 [4] = '{4'h0, 4'hA, 4'h0, 4'h6};

    logic [3:0] q4  [4];
    logic [3:0] qn4 [4];
    logic       inv4[4];
    logic       q1  [2];
    logic       qn1 [2];
    logic       inv1[2];
`ifdef SR_ILLEGAL_CNT_EN
    logic [7:0] cnt4[4];
    logic [7:0] cnt1[2];
`endif

    // reference state
    logic [3:0] m4[4];
    logic       m1[2];
    logic       mi4, mi1;
    int         mc4, mc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_w4
        sr_latch_if #(.WIDTH(4)) bus ();
        assign bus.en = en;
        assign bus.S  = s4;
        assign bus.R  = r4;
        sr_latch #(.WIDTH(4), .RESET_VAL(RV4[g]), .BOTH_POLICY(g)) dut (
            .clk(clk), .rst(rst), .bus(bus));
        assign q4[g]   = bus.Q;
        assign qn4[g]  = bus.Qn;
        assign inv4[g] = bus.invalid;
`ifdef SR_ILLEGAL_CNT_EN
        assign cnt4[g] = bus.illegal_cnt;
`endif
    end

    // single-bit instances: index 0 holds on conflict, index 1 toggles
    for (genvar g = 0; g < 2; g++) begin : g_w1
        sr_latch_if #(.WIDTH(1)) bus ();
        assign bus.en = en;
        assign bus.S  = s1;
        assign bus.R  = r1;
        sr_latch #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_POLICY(g * 3)) dut (
            .clk(clk), .rst(rst), .bus(bus));
        assign q1[g]   = bus.Q;
        assign qn1[g]  = bus.Qn;
        assign inv1[g] = bus.invalid;
`ifdef SR_ILLEGAL_CNT_EN
        assign cnt1[g] = bus.illegal_cnt;
`endif
    end

    // Next state as set algebra: set-only bits go high, reset-only bits go low,
    // conflicting bits resolved by policy over the whole vector at once.
    function automatic logic [3:0] ref_next(logic [3:0] q, logic [3:0] s,
                                            logic [3:0] r, int pol);
        logic [3:0] both;
        logic [3:0] res;
        both = s & r;
        res  = (q | (s & ~r)) & ~(r & ~s);
        case (pol)
            1:       res = res | both;
            2:       res = res & ~both;
            3:       res = res ^ both;
            default: res = res;
        endcase
        return res;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 4; g++) m4[g] = RV4[g];
        for (int g = 0; g < 2; g++) m1[g] = 1'b0;
        mi4 = 1'b0; mi1 = 1'b0; mc4 = 0; mc1 = 0;
    endtask

    task automatic model_edge();
        logic [3:0] t;
        if (en) begin
            for (int g = 0; g < 4; g++) m4[g] = ref_next(m4[g], s4, r4, g);
            for (int g = 0; g < 2; g++) begin
                t = ref_next({3'b0, m1[g]}, {3'b0, s1}, {3'b0, r1}, g * 3);
                m1[g] = t[0];
            end
        end
        mi4 = en && ((s4 & r4) != 4'h0);
        mi1 = en && s1 && r1;
        if (mi4 && mc4 < 255) mc4++;
        if (mi1 && mc1 < 255) mc1++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s q4[%0d]", tag, g),   {28'b0, q4[g]},  {28'b0, m4[g]});
            chk($sformatf("%s qn4[%0d]", tag, g),  {28'b0, qn4[g]}, {28'b0, ~m4[g]});
            chk($sformatf("%s inv4[%0d]", tag, g), {31'b0, inv4[g]}, {31'b0, mi4});
`ifdef SR_ILLEGAL_CNT_EN
            chk($sformatf("%s cnt4[%0d]", tag, g), {24'b0, cnt4[g]}, mc4);
`endif
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s q1[%0d]", tag, g),   {31'b0, q1[g]},  {31'b0, m1[g]});
            chk($sformatf("%s qn1[%0d]", tag, g),  {31'b0, qn1[g]}, {31'b0, ~m1[g]});
            chk($sformatf("%s inv1[%0d]", tag, g), {31'b0, inv1[g]}, {31'b0, mi1});
`ifdef SR_ILLEGAL_CNT_EN
            chk($sformatf("%s cnt1[%0d]", tag, g), {24'b0, cnt1[g]}, mc1);
`endif
        end
    endtask

    // One rising edge; inputs were driven at the preceding falling edge.
    task automatic step(string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(logic e, logic s_1, logic r_1, logic [3:0] s_4, logic [3:0] r_4);
        en = e; s1 = s_1; r1 = r_1; s4 = s_4; r4 = r_4;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        #2;
        model_reset();
        check_all("reset_no_clk");

        @(negedge clk);
        rst = 1'b0;
        step("en0_hold_a");
        step("en0_hold_b");

        drive(1'b1, 1'b0, 1'b1, 4'h0, 4'hF);
        step("reset_bit");
        drive(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        step("en_gate");
        drive(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        step("set");
        chk("set_q1_const", {31'b0, q1[0]}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) step("hold");

        drive(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        step("conflict_a");
        chk("toggle_first", {31'b0, q1[1]}, 32'd0);
        step("conflict_b");
        chk("toggle_second", {31'b0, q1[1]}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        step("invalid_drop");

        // asynchronous reset between edges, with set still applied
        drive(1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        step("rst_held_a");
        step("rst_held_b");
        rst = 1'b0;
        step("rst_release");
        chk("rst_release_q1", {31'b0, q1[0]}, 32'd1);

        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'hF);
        step("w4_clear");
        drive(1'b1, 1'b0, 1'b0, 4'b0101, 4'b0011);
        step("w4_conflict");
        chk("w4_q_const",  {28'b0, q4[0]},  32'h4);
        chk("w4_qn_const", {28'b0, qn4[0]}, 32'hB);

        for (int n = 0; n < 250; n++) begin
            drive($urandom_range(3) != 0, 1'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom));
            if ($urandom_range(39) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rand_async");
                step("rand_rst_edge");
                rst = 1'b0;
            end else begin
                step("rand");
            end
        end

        // long conflict run drives the counter into saturation
        drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        for (int n = 0; n < 270; n++) step("sat");
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        step("sat_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
